// File: rtl/flit_checksum_unit_pkg.sv
// Body geometry for the flit checksum: body width, byte count, padded vector type.
// The body is zero-extended on the MSB side to a whole number of bytes.
package flit_checksum_unit_pkg;
   import types::*;

   localparam int BODY_WIDTH      = FLIT_WIDTH - CHECKSUM_WIDTH;
   localparam int FLIT_BODY_BYTES = (BODY_WIDTH + 7) / 8;
   localparam int BODY_PAD_WIDTH  = FLIT_BODY_BYTES * 8;

   typedef logic [BODY_WIDTH-1:0]     body_t;
   typedef logic [BODY_PAD_WIDTH-1:0] body_pad_t;

endpackage

// File: rtl/types.sv
// Shared NoC flit types: header, flit id, payload union and checksum field.
// Checksum occupies the flit LSBs so the body is everything above it.
package types;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flittype_t;

   typedef struct packed {
      logic [7:0] packet_id;
      logic [3:0] flit_num;
   } flit_id_t;

   typedef struct packed {
      flittype_t  flit_type;
      logic [1:0] version;
      logic       is_ack;
      logic [3:0] src;
      logic [3:0] dst;
      flit_id_t   flit_id;
   } header_t;

   typedef union packed {
      logic [31:0] head;
      logic [31:0] body;
   } payload_t;

   localparam int CHECKSUM_WIDTH = 8;
   typedef logic [CHECKSUM_WIDTH-1:0] checksum_t;

   typedef struct packed {
      header_t   header;
      payload_t  payload;
      checksum_t checksum;
   } flit_t;

   localparam int FLIT_WIDTH = $bits(flit_t);

endpackage

// File: rtl/flit_checksum_unit_byte_sum.sv
// Modulo-256 sum of all bytes of the padded flit body.
// Latency: combinational. Backpressure: none, pure function of the input.
// Module: checksum_byte_sum.
module checksum_byte_sum
   import types::*;
   import flit_checksum_unit_pkg::*;
(
   input  body_pad_t body,
   output checksum_t sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < FLIT_BODY_BYTES; i++) begin
         sum = sum + body[i*8 +: 8];
      end
   end

endmodule

// File: rtl/flit_checksum_unit.sv
// Flit checksum stamp/check: negated byte sum of {header, payload}, match flag, rewritten flit.
// Latency: checksum/is_valid/flit_out combinational; err_sticky (and err_count) registered.
// Backpressure: none; CHECKSUM_ERR_CNT_EN adds a saturating 16-bit error counter.
module flit_checksum_unit
   import types::*;
   import flit_checksum_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  flit_t       flit_in,
   input  logic        flit_in_valid,
   output checksum_t   checksum,
   output logic        is_valid,
   output flit_t       flit_out,
`ifdef CHECKSUM_ERR_CNT_EN
   output logic [15:0] err_count,
`endif
   output logic        err_sticky
);

   body_t     body;
   body_pad_t body_pad;
   checksum_t body_sum;
   logic      err_hit;

   assign body     = {flit_in.header, flit_in.payload};
   assign body_pad = body_pad_t'(body);

   checksum_byte_sum u_byte_sum (
      .body (body_pad),
      .sum  (body_sum)
   );

   // Two's-complement negation makes body bytes + checksum sum to zero mod 256.
   assign checksum = checksum_t'(~body_sum + 8'd1);
   assign is_valid = (flit_in.checksum == checksum);

   always_comb begin
      flit_out          = flit_in;
      flit_out.checksum = checksum;
   end

   assign err_hit = flit_in_valid && !is_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (err_hit) begin
         err_sticky <= 1'b1;
      end
   end

`ifdef CHECKSUM_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_flit_checksum_unit.sv
// Directed and random checks of flit_checksum_unit; counter checks when CHECKSUM_ERR_CNT_EN is defined.
module tb_flit_checksum_unit;
   import types::*;

   logic        clk;
   logic        rst_n;
   flit_t       flit_in;
   logic        flit_in_valid;
   checksum_t   checksum;
   logic        is_valid;
   flit_t       flit_out;
   logic        err_sticky;
`ifdef CHECKSUM_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   int n_vec;
   int n_bad;

   flit_checksum_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flit_in       (flit_in),
      .flit_in_valid (flit_in_valid),
      .checksum      (checksum),
      .is_valid      (is_valid),
      .flit_out      (flit_out),
`ifdef CHECKSUM_ERR_CNT_EN
      .err_count     (err_count),
`endif
      .err_sticky    (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flit with the given payload and checksum field, all header fields zero.
   function automatic flit_t mk(input logic [31:0] pl, input checksum_t cs);
      flit_t f;
      f = '0;
      f.header.flit_type = HEAD;
      f.payload.head = pl;
      f.checksum = cs;
      return f;
   endfunction

   // Reference: sum eight body bytes of the 64-bit zero-extended body, then negate.
   function automatic checksum_t ref_cs(input logic [64:0] raw);
      logic [63:0] b;
      int          acc;
      b = {7'd0, raw[64:8]};
      acc = 0;
      for (int i = 0; i < 8; i++) acc += int'(b[i*8 +: 8]);
      return checksum_t'((256 - (acc % 256)) % 256);
   endfunction

   initial begin
      logic [64:0] raw;
      logic [31:0] r0, r1, r2;
      checksum_t   exp_cs;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      flit_in_valid = 1'b0;
      flit_in = mk(32'h0, 8'h00);
      #1;

      // All-zero flit.
      chk("zero_cs", 128'(checksum), 128'h00);
      chk("zero_valid", 128'(is_valid), 128'h1);
      chk("zero_hdr", 128'(flit_out.header), 128'(flit_in.header));
      chk("zero_pl", 128'(flit_out.payload), 128'(flit_in.payload));
      chk("zero_ocs", 128'(flit_out.checksum), 128'h00);
      chk("rst_sticky", 128'(err_sticky), 128'h0);

      // Single 0x01 body byte.
      flit_in = mk(32'h1, 8'h00); #1;
      chk("one_cs", 128'(checksum), 128'hFF);
      chk("one_bad", 128'(is_valid), 128'h0);
      chk("one_ocs", 128'(flit_out.checksum), 128'hFF);
      chk("one_pl", 128'(flit_out.payload), 128'h1);
      chk("one_hdr", 128'(flit_out.header), 128'h0);
      flit_in = mk(32'h1, 8'hFF); #1;
      chk("one_good", 128'(is_valid), 128'h1);

      // Wraparound and a mixed pair.
      flit_in = mk(32'h8080, 8'h00); #1;
      chk("wrap_cs", 128'(checksum), 128'h00);
      flit_in = mk(32'h3412, 8'h00); #1;
      chk("pair_cs", 128'(checksum), 128'hBA);

      // All 57 body bits set: 7 x 0xFF + 0x01 = 0x6FA -> checksum 0x06.
      flit_in = flit_t'({57'h1FF_FFFF_FFFF_FFFF, 8'h06}); #1;
      chk("ones_cs", 128'(checksum), 128'h06);
      chk("ones_valid", 128'(is_valid), 128'h1);

      // Sticky error tracking.
      tick();
      chk("rst_hold", 128'(err_sticky), 128'h0);
      rst_n = 1'b1;
      flit_in = mk(32'h1, 8'h00);
      flit_in_valid = 1'b0;
      repeat (3) tick();
      chk("nostrobe", 128'(err_sticky), 128'h0);
      flit_in_valid = 1'b1;
      tick();
      chk("sticky_set", 128'(err_sticky), 128'h1);
      flit_in = mk(32'h1, 8'hFF);
      repeat (2) tick();
      chk("sticky_hold", 128'(err_sticky), 128'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clr", 128'(err_sticky), 128'h0);
      chk("rst_comb", 128'(is_valid), 128'h1);
      flit_in_valid = 1'b0;
      tick();
      rst_n = 1'b1;

`ifdef CHECKSUM_ERR_CNT_EN
      chk("cnt_rst", 128'(err_count), 128'h0);
      flit_in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         flit_in = (i % 3 == 1) ? mk(32'h3412, 8'hBA) : mk(32'h3412, 8'h00);
         tick();
      end
      chk("cnt_five", 128'(err_count), 128'd5);
      flit_in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("cnt_clr", 128'(err_count), 128'h0);
      flit_in = mk(32'h1, 8'h00);
      flit_in_valid = 1'b1;
      repeat (65535) tick();
      chk("cnt_max", 128'(err_count), 128'hFFFF);
      repeat (2) tick();
      chk("cnt_sat", 128'(err_count), 128'hFFFF);
      flit_in_valid = 1'b0;
`endif

      // Random flits against the reference model.
      for (int i = 0; i < 1000; i++) begin
         r0 = $urandom;
         r1 = $urandom;
         r2 = $urandom;
         raw = {r2[0], r1, r0};
         exp_cs = ref_cs(raw);
         if (r2[1]) raw[7:0] = exp_cs;
         flit_in = raw;
         #1;
         chk("rnd_cs", 128'(checksum), 128'(exp_cs));
         chk("rnd_valid", 128'(is_valid), 128'(raw[7:0] == exp_cs));
         chk("rnd_body", 128'(flit_out[64:8]), 128'(raw[64:8]));
         chk("rnd_ocs", 128'(flit_out.checksum), 128'(exp_cs));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/flit_checksum_unit.md
Name: flit_checksum_unit

Overview:
- Combinational checksum generator and checker for one NoC flit (`types::flit_t`).
- Computes the 8-bit checksum over header and payload, and flags whether the incoming checksum field matches.
- Outputs a copy of the flit with the checksum field rewritten.
- Sits on the flit path at both ends: the transmit side stamps outgoing flits; the receive side checks incoming flits and records checksum errors.

Parameters:
- None. All widths come from the `types` package: `flit_t`, `checksum_t` (8 bits), `FLIT_WIDTH`.

Ports:
- `clk`  input  1  system clock; used only by the error-tracking registers.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `flit_in`  input  `$bits(types::flit_t)`  flit under test (`header`, `payload`, `checksum`).
- `flit_in_valid`  input  1  strobe: `flit_in` is a real flit this cycle. Affects only the error-tracking registers.
- `checksum`  output  `types::checksum_t` (8)  computed checksum of `flit_in.header` + `flit_in.payload`.
- `is_valid`  output  1  high when `flit_in.checksum` equals the computed checksum.
- `flit_out`  output  `$bits(types::flit_t)`  `flit_in` with the `checksum` field replaced by the computed checksum.
- `err_sticky`  output  1  registered; set on any strobed flit with a bad checksum.

Behaviour:
- Body = concatenation `{header, payload}`. It is the flit minus the 8-bit checksum field.
- The body is zero-padded on the MSB side to a whole number of bytes, then split into bytes.
- `sum` = modulo-256 sum of all body bytes.
- `checksum` = (256 − `sum`) mod 256, i.e. two's-complement negation. Consequence: body bytes + `checksum` ≡ 0 mod 256.
- All-zero body gives `checksum` = 0x00.
- `is_valid` = (`flit_in.checksum` == `checksum`).
- `flit_out.header` = `flit_in.header`; `flit_out.payload` = `flit_in.payload`; `flit_out.checksum` = `checksum`.
- `checksum`, `is_valid` and `flit_out` are purely combinational:
  - zero-cycle latency;
  - no dependence on `clk`, `rst_n` or `flit_in_valid`;
  - settle within the same delta/step as `flit_in`.
- Checksum is computed identically for every flit type (HEAD, BODY, TAIL, ...) and for `is_ack` set or clear.
- No X-propagation masking: X on `flit_in` may give X outputs.
- `err_sticky`:
  - 0 while `rst_n` is low, cleared asynchronously.
  - At a `posedge clk` with `flit_in_valid` = 1 and `is_valid` = 0, it becomes 1 and holds until reset.
  - `flit_in_valid` = 0 never changes it.
- Reset asserted mid-operation clears `err_sticky` immediately. The combinational outputs keep tracking `flit_in` during reset.

Optional Feature:
- Macro: `CHECKSUM_ERR_CNT_EN`.
- Defined:
  - Adds output `err_count` [15:0].
  - Async reset to 0.
  - Increments at `posedge clk` when `flit_in_valid` && !`is_valid`.
  - Saturates at 0xFFFF; no wrap.
- Undefined:
  - Port `err_count` and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package `types` (already present) owns:
  - `flit_t`, `header_t`, `flit_id_t`, payload union, `flittype_t` enum (HEAD, ...);
  - `checksum_t` (`logic [7:0]`);
  - `FLIT_WIDTH`, `CHECKSUM_WIDTH` = 8.
- New package constant: `FLIT_BODY_BYTES` = ceil((`FLIT_WIDTH` − 8)/8).
- One natural sub-module, `checksum_byte_sum`: a pure function/adder tree producing `sum` from the padded body. The top instantiates it and adds negation, compare, flit rewrite and error registers.

Test Plan:
1. All-zero flit (HEAD, `version` 0, `is_ack` 0, `src`/`dst` 0, `packet_id` 0, `flit_num` 0, `payload.head` 0), `flit_in.checksum` 0x00 -> `checksum` 0x00, `is_valid` 1, `flit_out` == `flit_in` field-by-field.
2. Body LSB byte 0x01, all else 0, `flit_in.checksum` 0x00 -> `checksum` 0xFF, `is_valid` 0, `flit_out.checksum` 0xFF, header/payload unchanged. Same body with `flit_in.checksum` 0xFF -> `is_valid` 1.
3. Wrap: two body bytes 0x80 and 0x80, rest 0 -> `sum` 0x00, `checksum` 0x00. Body bytes 0x12, 0x34 -> `checksum` 0xBA.
4. Sticky error: reset low → `err_sticky` 0. Release reset, apply bad flit from (2) with `flit_in_valid` 0 for 3 cycles -> `err_sticky` stays 0. Assert `flit_in_valid` 1 for one cycle -> `err_sticky` 1 after that edge. Apply good flits -> stays 1. Assert `rst_n` low mid-cycle -> `err_sticky` 0 without waiting for a clock.
5. With `CHECKSUM_ERR_CNT_EN`: 5 strobed bad flits interleaved with 3 strobed good flits -> `err_count` 5. Preload via 65535 bad strobes, then 2 more -> `err_count` holds 0xFFFF.
6. Random: 1000 random `flit_in`; `checksum` matches the reference model (negated byte sum). `is_valid` set exactly when fields match; `flit_out` header/payload always equal input.
